// File: rtl/alu_pkg.sv
// Op codes, multicycle classification and FSM state encoding shared by the ALU issue queue.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_GT   = 3'd2;
  localparam logic [2:0] OP_EQ   = 3'd3;
  localparam logic [2:0] OP_LT   = 3'd4;
  localparam logic [2:0] OP_MUL0 = 3'd5;
  localparam logic [2:0] OP_MUL1 = 3'd6;
  localparam logic [2:0] OP_MAC  = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  function automatic logic is_multicycle(input logic [2:0] sel);
    return (sel == OP_MUL0) || (sel == OP_MUL1) || (sel == OP_MAC);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty/level and a peek at the entry behind the head.
// Caller guarantees no push when full and no pop when empty.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_nxt_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW-1:0] w_nxt_ptr;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_nxt_ptr = r_rd_ptr + 1'b1;
  assign o_nxt_dat = r_mem[w_nxt_ptr];
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands, holds the head on registered ALU inputs and captures a tagged result.
// Latency 1+MUL_WAIT cycles from acceptance into an empty queue; stalls on rsp_ready low, cmd_ready = !full.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 4,
  parameter int TW       = 4,
  parameter int MUL_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_sel,
  input  logic [N-1:0]           cmd_a,
  input  logic [N-1:0]           cmd_b,
  input  logic [N-1:0]           cmd_c,
  input  logic [TW-1:0]          cmd_tag,
  output logic [N-1:0]           alu_num1,
  output logic [N-1:0]           alu_num2,
  output logic [N-1:0]           alu_num3,
  output logic [2:0]             alu_sel,
  input  logic [N-1:0]           alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N-1:0]           rsp_data,
  output logic [TW-1:0]          rsp_tag,
  output logic [2:0]             rsp_sel,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW  = 3 + 3*N + TW;
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

  state_e         r_state;
  logic [WCW-1:0] r_wcnt;
  logic [2:0]     r_alu_sel;
  logic [N-1:0]   r_alu_a, r_alu_b, r_alu_c;
  logic [TW-1:0]  r_alu_tag;
  logic           r_rsp_vld;
  logic [N-1:0]   r_rsp_dat;
  logic [TW-1:0]  r_rsp_tag;
  logic [2:0]     r_rsp_sel;

  logic           w_push, w_cap, w_more, w_wait_done;
  logic           w_full, w_empty;
  logic [LW-1:0]  w_level;
  logic [WCW-1:0] w_need;
  logic [CW-1:0]  w_cmd_pk, w_fifo_nxt, w_ld_dat;
  logic [2:0]     w_ld_sel;
  logic [N-1:0]   w_ld_a, w_ld_b, w_ld_c;
  logic [TW-1:0]  w_ld_tag;

  assign w_cmd_pk = {cmd_sel, cmd_a, cmd_b, cmd_c, cmd_tag};

  alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_cmd_pk),
    .i_pop      (w_cap),
    .o_nxt_dat  (w_fifo_nxt),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  assign w_push      = cmd_valid && !w_full;
  assign w_need      = is_multicycle(r_alu_sel) ? WCW'(MUL_WAIT) : '0;
  assign w_wait_done = (r_wcnt >= w_need);
  assign w_cap       = (r_state == S_EXEC) && !w_empty && w_wait_done
                       && (!r_rsp_vld || rsp_ready);
  assign w_more      = (w_level > LW'(1)) || w_push;
  // With a single entry left, the next head can only be the command arriving this cycle.
  assign w_ld_dat    = (w_level > LW'(1)) ? w_fifo_nxt : w_cmd_pk;
  assign {w_ld_sel, w_ld_a, w_ld_b, w_ld_c, w_ld_tag} = w_ld_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_alu_sel <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_c   <= '0;
      r_alu_tag <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_tag <= '0;
      r_rsp_sel <= '0;
    end else begin
      if (w_cap) begin
        r_rsp_vld <= 1'b1;
        r_rsp_dat <= alu_out;
        r_rsp_tag <= r_alu_tag;
        r_rsp_sel <= r_alu_sel;
      end else if (rsp_ready) begin
        r_rsp_vld <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state   <= S_EXEC;
            r_wcnt    <= '0;
            r_alu_sel <= w_ld_sel;
            r_alu_a   <= w_ld_a;
            r_alu_b   <= w_ld_b;
            r_alu_c   <= w_ld_c;
            r_alu_tag <= w_ld_tag;
          end
        end
        S_EXEC: begin
          if (!w_wait_done) begin
            r_wcnt <= r_wcnt + 1'b1;
          end else if (w_cap) begin
            if (w_more) begin
              r_wcnt    <= '0;
              r_alu_sel <= w_ld_sel;
              r_alu_a   <= w_ld_a;
              r_alu_b   <= w_ld_b;
              r_alu_c   <= w_ld_c;
              r_alu_tag <= w_ld_tag;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign alu_num1  = r_alu_a;
  assign alu_num2  = r_alu_b;
  assign alu_num3  = r_alu_c;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_rsp_dat;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_sel   = r_rsp_sel;
  assign level     = w_level;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU closing the loop.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sel;
  logic [31:0] cmd_a, cmd_b, cmd_c;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_num1, alu_num2, alu_num3;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [2:0]  rsp_sel;
  logic [2:0]  level;
  logic [63:0] prod;

  int n_assert = 0;
  int n_fail   = 0;

  alu_issue_queue #(.N(32), .DEPTH(4), .TW(4), .MUL_WAIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_tag   (cmd_tag),
    .alu_num1  (alu_num1),
    .alu_num2  (alu_num2),
    .alu_num3  (alu_num3),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_sel   (rsp_sel),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    prod    = {32'd0, alu_num1} * {32'd0, alu_num2};
    alu_out = 32'd0;
    case (alu_sel)
      OP_ADD:  alu_out = alu_num1 + alu_num2;
      OP_SUB:  alu_out = alu_num1 - alu_num2;
      OP_GT:   alu_out = {31'd0, alu_num1 > alu_num2};
      OP_EQ:   alu_out = {31'd0, alu_num1 == alu_num2};
      OP_LT:   alu_out = {31'd0, alu_num1 < alu_num2};
      OP_MUL0: alu_out = prod[31:0];
      OP_MUL1: alu_out = prod[63:32];
      default: alu_out = prod[31:0] + alu_num3;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [3:0] t);
    cmd_valid = v;
    cmd_sel   = s;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = c;
    cmd_tag   = t;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_level",     32'(level),     32'd0);
    check("rst_alu_sel",   32'(alu_sel),   32'd0);
    check("rst_alu_num1",  alu_num1,       32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    rst_n = 1'b1;

    // Single add
    drive(1'b1, OP_ADD, 32'd5, 32'd3, 32'd0, 4'd1);
    tick();
    cmd_valid = 1'b0;
    check("add_alu_num1",  alu_num1,        32'd5);
    check("add_alu_num2",  alu_num2,        32'd3);
    check("add_pre_valid", 32'(rsp_valid),  32'd0);
    check("add_level",     32'(level),      32'd1);
    tick();
    check("add_valid",     32'(rsp_valid),  32'd1);
    check("add_data",      rsp_data,        32'd8);
    check("add_tag",       32'(rsp_tag),    32'd1);
    check("add_sel",       32'(rsp_sel),    32'd0);
    check("add_level0",    32'(level),      32'd0);
    tick();
    check("add_drained",   32'(rsp_valid),  32'd0);

    // Sub wrap followed directly by eq
    drive(1'b1, OP_SUB, 32'd0, 32'd1, 32'd0, 4'd2);
    tick();
    drive(1'b1, OP_EQ, 32'd7, 32'd7, 32'd0, 4'd3);
    check("sub_alu_sel",   32'(alu_sel),    32'd1);
    tick();
    cmd_valid = 1'b0;
    check("sub_data",      rsp_data,        32'hFFFF_FFFF);
    check("sub_tag",       32'(rsp_tag),    32'd2);
    check("sub_sel",       32'(rsp_sel),    32'd1);
    check("eq_alu_sel",    32'(alu_sel),    32'd3);
    tick();
    check("eq_valid",      32'(rsp_valid),  32'd1);
    check("eq_data",       rsp_data,        32'd1);
    check("eq_tag",        32'(rsp_tag),    32'd3);
    tick();

    // Multicycle mul then add
    drive(1'b1, OP_MUL0, 32'd6, 32'd7, 32'd0, 4'd4);
    tick();
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 4'd5);
    check("mul_hold0_sel", 32'(alu_sel),    32'd5);
    check("mul_hold0_a",   alu_num1,        32'd6);
    check("mul_hold0_vld", 32'(rsp_valid),  32'd0);
    tick();
    cmd_valid = 1'b0;
    check("mul_hold1_b",   alu_num2,        32'd7);
    check("mul_hold1_vld", 32'(rsp_valid),  32'd0);
    check("mul_level2",    32'(level),      32'd2);
    tick();
    check("mul_hold2_a",   alu_num1,        32'd6);
    check("mul_hold2_vld", 32'(rsp_valid),  32'd0);
    tick();
    check("mul_valid",     32'(rsp_valid),  32'd1);
    check("mul_data",      rsp_data,        32'd42);
    check("mul_tag",       32'(rsp_tag),    32'd4);
    check("mul_sel",       32'(rsp_sel),    32'd5);
    check("next_head_sel", 32'(alu_sel),    32'd0);
    check("next_head_a",   alu_num1,        32'd1);
    tick();
    check("post_add_data", rsp_data,        32'd3);
    check("post_add_tag",  32'(rsp_tag),    32'd5);
    check("post_add_lvl",  32'(level),      32'd0);
    tick();

    // Backpressure until full
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_ADD, 32'((6 + i) * 10), 32'd1, 32'd0, 4'(6 + i));
      tick();
    end
    drive(1'b1, OP_ADD, 32'd110, 32'd1, 32'd0, 4'd11);
    check("full_ready",    32'(cmd_ready),  32'd0);
    check("full_level",    32'(level),      32'd4);
    tick();
    tick();
    check("stall_level",   32'(level),      32'd4);
    check("stall_ready",   32'(cmd_ready),  32'd0);
    check("stall_valid",   32'(rsp_valid),  32'd1);
    check("stall_tag",     32'(rsp_tag),    32'd6);
    check("stall_data",    rsp_data,        32'd61);
    check("stall_alu_a",   alu_num1,        32'd70);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_valid", 32'(rsp_valid),  32'd1);
      check("drain_tag",   32'(rsp_tag),    32'(7 + i));
      check("drain_data",  rsp_data,        32'((7 + i) * 10 + 1));
      check("drain_level", 32'(level),      (i == 0) ? 32'd3 : 32'(4 - i));
      if (i == 0) check("drain_ready", 32'(cmd_ready), 32'd1);
      if (i == 1) cmd_valid = 1'b0;
    end
    tick();
    check("drain_empty",   32'(rsp_valid),  32'd0);

    // Streaming adds
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_ADD, 32'(i + 1), 32'd100, 32'd0, 4'(i + 1));
      tick();
      check("stream_level", 32'(level), 32'd1);
      if (i == 0) check("stream_first", 32'(rsp_valid), 32'd0);
      else begin
        check("stream_valid", 32'(rsp_valid), 32'd1);
        check("stream_tag",   32'(rsp_tag),   32'(i));
        check("stream_data",  rsp_data,       32'(i + 100));
      end
    end
    cmd_valid = 1'b0;
    tick();
    check("stream_last_tag",  32'(rsp_tag), 32'd5);
    check("stream_last_data", rsp_data,     32'd105);
    check("stream_lvl0",      32'(level),   32'd0);

    // Reset in the middle of a mul wait
    rsp_ready = 1'b0;
    drive(1'b1, OP_MUL0, 32'd3, 32'd4, 32'd0, 4'd2);
    tick();
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 4'd3);
    tick();
    check("pre_rst_level", 32'(level),     32'd2);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(rsp_valid), 32'd0);
    check("arst_level",    32'(level),     32'd0);
    check("arst_ready",    32'(cmd_ready), 32'd1);
    check("arst_alu_sel",  32'(alu_sel),   32'd0);
    check("arst_alu_a",    alu_num1,       32'd0);
    check("arst_rsp_data", rsp_data,       32'd0);
    check("arst_rsp_tag",  32'(rsp_tag),   32'd0);
    cmd_valid = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd9, 32'd9, 32'd0, 4'd7);
    tick();
    cmd_valid = 1'b0;
    check("post_rst_alu_a", alu_num1,       32'd9);
    check("post_rst_level", 32'(level),     32'd1);
    check("post_rst_nvld",  32'(rsp_valid), 32'd0);
    tick();
    check("post_rst_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_data",  rsp_data,       32'd18);
    check("post_rst_tag",   32'(rsp_tag),   32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
